arb_mux: RTL and testbench



---
 rtl/arb_mux.sv | 81 ++++++++
 tb/tb_arb_mux.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/arb_mux.sv
// arb_mux: N-channel valid/ready stream multiplexer with an internal
// round-robin or fixed-priority arbiter and a single registered output stage.
// The output register breaks every combinational path from the producers to
// the consumer. Only in_ready depends combinationally on in_valid/out_ready.
module arb_mux #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int RR    = 1,
  parameter int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  input  logic               out_ready
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(N - 1);

  logic [SEL_W-1:0] prio_ptr;
  logic             load;
  logic             gnt_any;
  logic [SEL_W-1:0] gnt_idx;
  logic [SEL_W-1:0] scan;
  logic [SEL_W-1:0] ptr_next;

  // The output register can take a new beat when it is empty or draining.
  assign load = !out_valid || out_ready;

  // Pointer follows the granted channel, wrapping from N-1 back to 0.
  assign ptr_next = (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;

  // Arbiter: walk the channels starting at prio_ptr (RR) or 0 (fixed) and
  // grant the first one that is valid.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    scan    = (RR != 0) ? prio_ptr : '0;
    for (int k = 0; k < N; k++) begin
      if (!gnt_any && in_valid[scan]) begin
        gnt_any = 1'b1;
        gnt_idx = scan;
      end
      scan = (scan == LAST) ? '0 : scan + 1'b1;
    end
  end

  // Ready goes only to the granted channel, and only when the register can load.
  always_comb begin
    in_ready = '0;
    if (load && gnt_any) begin
      in_ready[gnt_idx] = 1'b1;
    end
  end

  // Output register and priority pointer; everything held while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      prio_ptr  <= '0;
    end else if (load) begin
      if (gnt_any) begin
        out_valid <= 1'b1;
        out_data  <= in_data[int'(gnt_idx)*WIDTH +: WIDTH];
        out_sel   <= gnt_idx;
        if (RR != 0) begin
          prio_ptr <= ptr_next;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: one round-robin and one fixed-priority instance share the
// same stimulus; a behavioural model of both arbitration policies predicts
// in_ready and the registered outputs every cycle, plus directed constants.
module tb_arb_mux;

  localparam int WIDTH = 32;
  localparam int N     = 4;
  localparam int SEL_W = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic               out_ready;

  logic [N-1:0]       rr_ready,  fp_ready;
  logic               rr_valid,  fp_valid;
  logic [WIDTH-1:0]   rr_data,   fp_data;
  logic [SEL_W-1:0]   rr_sel,    fp_sel;

  always #5 clk = ~clk;

  arb_mux #(.WIDTH(WIDTH), .N(N), .RR(1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rr_ready), .out_valid(rr_valid), .out_data(rr_data),
    .out_sel(rr_sel), .out_ready(out_ready)
  );

  arb_mux #(.WIDTH(WIDTH), .N(N), .RR(0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(fp_ready), .out_valid(fp_valid), .out_data(fp_data),
    .out_sel(fp_sel), .out_ready(out_ready)
  );

  int npass  = 0;
  int nfail  = 0;
  int ntotal = 0;

  // Model state, index 0 = round-robin instance, index 1 = fixed priority.
  logic             mv[2];
  logic [WIDTH-1:0] md[2];
  int               ms[2];
  int               mp[2];

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Channel the policy would pick now, or -1 when nothing is valid.
  function automatic int grant(input int m);
    int c;
    for (int k = 0; k < N; k++) begin
      c = (m == 0) ? (mp[m] + k) % N : k;
      if (in_valid[c[SEL_W-1:0]]) return c;
    end
    return -1;
  endfunction

  function automatic int exp_ready(input int m);
    int g;
    g = grant(m);
    if ((!mv[m] || out_ready) && g >= 0) return 1 << g;
    return 0;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mv[m] = 1'b0; md[m] = '0; ms[m] = 0; mp[m] = 0;
    end
  endtask

  task automatic model_step();
    int g;
    for (int m = 0; m < 2; m++) begin
      g = grant(m);
      if (!mv[m] || out_ready) begin
        if (g >= 0) begin
          mv[m] = 1'b1;
          md[m] = in_data[g*WIDTH +: WIDTH];
          ms[m] = g;
          if (m == 0) mp[m] = (g + 1) % N;
        end else begin
          mv[m] = 1'b0;
        end
      end
    end
  endtask

  task automatic check_ready();
    chk("rr_in_ready", WIDTH'(rr_ready), WIDTH'(exp_ready(0)));
    chk("fp_in_ready", WIDTH'(fp_ready), WIDTH'(exp_ready(1)));
  endtask

  task automatic check_out();
    chk("rr_out_valid", WIDTH'(rr_valid), WIDTH'(mv[0]));
    chk("rr_out_data",  rr_data,          md[0]);
    chk("rr_out_sel",   WIDTH'(rr_sel),   WIDTH'(ms[0]));
    chk("fp_out_valid", WIDTH'(fp_valid), WIDTH'(mv[1]));
    chk("fp_out_data",  fp_data,          md[1]);
    chk("fp_out_sel",   WIDTH'(fp_sel),   WIDTH'(ms[1]));
  endtask

  // One clock: inputs set by the caller after a falling edge.
  task automatic cycle();
    #1;
    check_ready();
    @(posedge clk);
    if (rst_n) model_step();
    else model_reset();
    #1;
    check_out();
    @(negedge clk);
  endtask

  task automatic set_data_a0();
    for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = WIDTH'(32'hA0 + i);
  endtask

  initial begin
    // Reset with every channel requesting.
    rst_n     = 1'b0;
    in_valid  = 4'hF;
    out_ready = 1'b1;
    set_data_a0();
    model_reset();
    #1;
    chk("rst_rr_valid", WIDTH'(rr_valid), 0);
    chk("rst_rr_data",  rr_data,          0);
    chk("rst_rr_sel",   WIDTH'(rr_sel),   0);
    chk("rst_fp_valid", WIDTH'(fp_valid), 0);
    @(negedge clk);
    cycle();
    rst_n = 1'b1;
    #1;
    chk("rst_release_rr_ready", WIDTH'(rr_ready), 32'h1);

    // Round-robin fairness: 0,1,2,3,0,1 with no bubbles.
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("rr_seq_sel",   WIDTH'(rr_sel),   WIDTH'(k % 4));
      chk("rr_seq_data",  rr_data,          WIDTH'(32'hA0 + k % 4));
      chk("rr_seq_valid", WIDTH'(rr_valid), 1);
      chk("fp_seq_sel",   WIDTH'(fp_sel),   0);
    end

    // Wrap-around: grant 2, then 1010 gives 3 then 1.
    in_valid = 4'b0100;
    cycle();
    chk("wrap_sel2", WIDTH'(rr_sel), 2);
    chk("wrap_ptr3", WIDTH'(dut_rr.prio_ptr), 3);
    in_valid = 4'b1010;
    cycle();
    chk("wrap_sel3", WIDTH'(rr_sel), 3);
    chk("wrap_ptr0", WIDTH'(dut_rr.prio_ptr), 0);
    cycle();
    chk("wrap_sel1", WIDTH'(rr_sel), 1);
    chk("wrap_ptr2", WIDTH'(dut_rr.prio_ptr), 2);

    // Backpressure: hold 0x55 for three stalled cycles.
    in_valid = 4'b0001;
    in_data[0 +: WIDTH] = 32'h55;
    cycle();
    chk("bp_load", rr_data, 32'h55);
    out_ready = 1'b0;
    in_valid  = 4'hF;
    in_data[0 +: WIDTH] = 32'h66;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("bp_hold_data",  rr_data,          32'h55);
      chk("bp_hold_ready", WIDTH'(rr_ready), 0);
      chk("bp_hold_valid", WIDTH'(rr_valid), 1);
    end
    out_ready = 1'b1;
    cycle();
    chk("bp_resume_sel",  WIDTH'(rr_sel), 1);
    chk("bp_resume_data", rr_data,        32'hA1);

    // Fixed priority: 1100 always picks 2; then only 3 remains.
    in_valid = 4'b1100;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("fp_pick2", WIDTH'(fp_sel), 2);
    end
    in_valid = 4'b1000;
    cycle();
    chk("fp_pick3", WIDTH'(fp_sel), 3);

    // Idle: a single beat from channel 1, then nothing.
    set_data_a0();
    in_valid = 4'b0010;
    cycle();
    chk("idle_beat_valid", WIDTH'(rr_valid), 1);
    chk("idle_beat_data",  rr_data,          32'hA1);
    in_valid = 4'b0000;
    cycle();
    chk("idle_empty_valid", WIDTH'(rr_valid), 0);
    chk("idle_held_data",   rr_data,          32'hA1);
    chk("idle_held_sel",    WIDTH'(rr_sel),   1);
    cycle();

    // Reset while a stalled beat is held.
    in_valid  = 4'b0010;
    out_ready = 1'b0;
    cycle();
    chk("midrst_pre_valid", WIDTH'(rr_valid), 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_rr_valid", WIDTH'(rr_valid), 0);
    chk("midrst_fp_valid", WIDTH'(fp_valid), 0);
    chk("midrst_rr_data",  rr_data,          0);
    #1;
    rst_n     = 1'b1;
    in_valid  = 4'hF;
    out_ready = 1'b1;
    cycle();
    chk("postrst_sel", WIDTH'(rr_sel), 0);

    // Randomized traffic with random backpressure.
    for (int k = 0; k < 400; k++) begin
      in_valid = 4'($urandom);
      for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
